// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response channels over a
// little-endian word store. Define MEM_RESP_ADDR_CHECK_EN to flag misaligned/out-of-range accesses.
module mem_responder #(
    parameter int unsigned BYTES   = 1024,
    parameter logic [31:0] START   = 32'h10008000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned WORDS = BYTES / 4;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          lat_write;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wstrb;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [WORDS];

    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic          acc_err;
    logic          do_access;
    logic [IW-1:0] idx;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
    always_comb begin
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_write = lat_write;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_wstrb = lat_wstrb;
        end
        idx       = IW'(((acc_addr - START) >> 2) % WORDS);
        do_access = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == 4'd1));
`ifdef MEM_RESP_ADDR_CHECK_EN
        acc_err   = (acc_addr[1:0] != 2'b00) ||
                    (acc_addr < START) ||
                    ({1'b0, acc_addr} >= ({1'b0, START} + 33'(BYTES)));
`else
        acc_err   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (do_access) begin
                err_q <= acc_err;
                if (acc_write)    rdata_q <= '0;
                else if (acc_err) rdata_q <= 32'hDEADBEEF;
                else              rdata_q <= mem[idx];
            end
        end
    end

    // Storage is never cleared; a reset edge suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_write && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table plus scoreboard, and hand-written hold/reset sequences.
// Expectations follow MEM_RESP_ADDR_CHECK_EN when the macro is defined for the build.
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    mem_responder #(
        .BYTES(1024),
        .START(32'h10008000),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_edge    = 0;
    int prev_acc_edge = 0;
    logic last_valid = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Monitor: tracks accept edges, checks response latency, pops the scoreboard on handshake.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_valid = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                prev_acc_edge = acc_edge;
                acc_edge      = cyc + 1;
            end
            if (rsp_valid && !last_valid)
                check("latency", 32'(cyc + 1 - acc_edge), 32'(LAT));
            last_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got rdata %h, want no response", rsp_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                    check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] erd, input logic eerr,
                         input string name);
        exp_t e;
        int n;
        e.rdata = erd;
        e.err   = eerr;
        e.name  = name;
        exp_q.push_back(e);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 40);
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_accept: got req_ready 0 for %0d cycles, want 1", name, n);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d responses pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input logic eerr,
                       input string name);
        vec_t v;
        v.write = w;  v.addr = a;  v.wdata = d;  v.wstrb = s;
        v.exp_rdata = erd;  v.exp_err = eerr;  v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        add(1, 32'h10008004, 32'hCAFEF00D, 4'hF, 32'h0,        0, "st_cafe");
        add(0, 32'h10008004, 32'h0,        4'h0, 32'hCAFEF00D, 0, "ld_cafe");
        add(1, 32'h1000800C, 32'h11223344, 4'hF, 32'h0,        0, "st_full");
        add(1, 32'h1000800C, 32'hAABBCCDD, 4'h5, 32'h0,        0, "st_lanes");
        add(0, 32'h1000800C, 32'h0,        4'h0, 32'h11BB33DD, 0, "ld_merge");
        add(1, 32'h1000800C, 32'hFFFFFFFF, 4'h0, 32'h0,        0, "st_nostrb");
        add(0, 32'h1000800C, 32'h0,        4'h0, 32'h11BB33DD, 0, "ld_nostrb");
        add(1, 32'h10008000, 32'hA5A50001, 4'hF, 32'h0,        0, "st_w0");
        add(1, 32'h100083FC, 32'h0BADF00D, 4'hF, 32'h0,        0, "st_last");
        add(0, 32'h100083FC, 32'h0,        4'h0, 32'h0BADF00D, 0, "ld_last");
`ifdef MEM_RESP_ADDR_CHECK_EN
        add(0, 32'h10008002, 32'h0,        4'h0, 32'hDEADBEEF, 1, "ld_misalign");
        add(0, 32'h10008400, 32'h0,        4'h0, 32'hDEADBEEF, 1, "ld_above");
        add(1, 32'h10007FFC, 32'hFFFFFFFF, 4'hF, 32'h0,        1, "st_below");
        add(0, 32'h100083FC, 32'h0,        4'h0, 32'h0BADF00D, 0, "ld_after_below");
        add(0, 32'h10008000, 32'h0,        4'h0, 32'hA5A50001, 0, "ld_w0");
`else
        add(0, 32'h10008002, 32'h0,        4'h0, 32'hA5A50001, 0, "ld_lowbits");
        add(0, 32'h10008400, 32'h0,        4'h0, 32'hA5A50001, 0, "ld_wrap_hi");
        add(1, 32'h10007FFC, 32'hFFFFFFFF, 4'hF, 32'h0,        0, "st_wrap_lo");
        add(0, 32'h100083FC, 32'h0,        4'h0, 32'hFFFFFFFF, 0, "ld_after_wrap");
`endif

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
            if (i == 1) check("accept_gap", 32'(acc_edge - prev_acc_edge), 32'(LAT + 1));
            wait_done(vecs[i].name);
        end

        // Backpressure: response held for 5 cycles, a stray store attempt must be ignored.
        rsp_ready = 1'b0;
        issue(0, 32'h10008004, 32'h0, 4'h0, 32'hCAFEF00D, 0, "ld_hold");
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'hCAFEF00D);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            req_write = 1'b1;
            req_addr  = 32'h10008004;
            req_wdata = 32'h0;
            req_wstrb = 4'hF;
            req_valid = (k == 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done("ld_hold");
        issue(0, 32'h10008004, 32'h0, 4'h0, 32'hCAFEF00D, 0, "ld_after_stray");
        wait_done("ld_after_stray");

        // Reset during WAIT of a store: no commit, outputs back to reset values.
        issue(1, 32'h10008008, 32'h0, 4'hF, 32'h0, 0, "st_zero");
        wait_done("st_zero");
        issue(0, 32'h10008004, 32'h0, 4'h0, 32'hCAFEF00D, 0, "ld_pre_rst");
        wait_done("ld_pre_rst");
        req_write = 1'b1;
        req_addr  = 32'h10008008;
        req_wdata = 32'h12345678;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 40);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'h0);
        check("abort_rsp_err",   32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        issue(0, 32'h10008008, 32'h0, 4'h0, 32'h0, 0, "ld_after_abort");
        wait_done("ld_after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
